// File: rtl/dec_scan_reg_pkg.sv
// Shared types and decode helpers for the registered N-to-2^N decoder.
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Code 63 overflows the shift to zero, so the mask correctly becomes all ones.
    function automatic logic [63:0] thermo_mask(input logic [5:0] code);
        return (64'd2 << code) - 64'd1;
    endfunction

    function automatic logic [63:0] onehot_mask(input logic [5:0] code);
        return 64'd1 << code;
    endfunction

endpackage

// File: rtl/dec_scan_reg_if.sv
// Control/handshake bundle between the decoder and its driving logic.
interface dec_scan_reg_if #(parameter int unsigned N = 2);
    import dec_pkg::*;

    logic              en;
    mode_e             mode;
    logic [N-1:0]      din;
    logic              din_valid;
    logic              din_ready;
    logic [(1<<N)-1:0] dout;
    logic              dout_valid;
    logic [N-1:0]      scan_idx;

    modport master (
        output en, mode, din, din_valid,
        input  din_ready, dout, dout_valid, scan_idx
    );

    modport slave (
        input  en, mode, din, din_valid,
        output din_ready, dout, dout_valid, scan_idx
    );

endinterface

// File: rtl/dec_scan_reg_ctr.sv
// Scan prescaler and index counter; step pulses in the cycle the index advances.
module dec_scan_ctr #(
    parameter int unsigned N        = 2,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
    output logic         step,
    output logic [N-1:0] idx
);

    localparam int unsigned    PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [N-1:0]  idx_q, idx_d;

    always_comb begin
        psc_d = psc_q;
        idx_d = idx_q;
        step  = 1'b0;
        if (start) begin
            psc_d = '0;
            idx_d = '0;
        end else if (en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                idx_d = idx_q + 1'b1;
                step  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= '0;
            idx_q <= '0;
        end else begin
            psc_q <= psc_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/dec_scan_reg.sv
// Registered N-to-2^N decoder with one-hot, thermometer and self-timed scan modes.
module dec_scan_reg
    import dec_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned OUT_INV  = 0
) (
    input  logic           clk,
    input  logic           rst,
    dec_scan_reg_if.slave  bus
);

    localparam int unsigned   W        = 1 << N;
    localparam logic [W-1:0] INV_MASK = (OUT_INV != 0) ? {W{1'b1}} : {W{1'b0}};

    mode_e        prev_mode_q, prev_mode_d;
    logic [W-1:0] dout_q, dout_d;
    logic         dout_valid_q, dout_valid_d;

    logic         in_scan;
    logic         scan_start;
    logic         scan_step;
    logic         xfer;
    logic [N-1:0] scan_idx;
    logic [N-1:0] idx_next;

    assign in_scan       = bus.en && (bus.mode == MODE_SCAN);
    // prev_mode only advances while enabled, so a frozen block never sees a false entry.
    assign scan_start    = in_scan && (prev_mode_q != MODE_SCAN);
    assign bus.din_ready = bus.en && ((bus.mode == MODE_ONEHOT) || (bus.mode == MODE_THERMO));
    assign xfer          = bus.din_ready && bus.din_valid;
    assign idx_next      = scan_idx + 1'b1;

    dec_scan_ctr #(
        .N        (N),
        .SCAN_DIV (SCAN_DIV)
    ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (in_scan),
        .start (scan_start),
        .step  (scan_step),
        .idx   (scan_idx)
    );

    always_comb begin
        prev_mode_d  = bus.en ? bus.mode : prev_mode_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (xfer) begin
            if (bus.mode == MODE_THERMO) begin
                dout_d = W'(thermo_mask(6'(bus.din))) ^ INV_MASK;
            end else begin
                dout_d = W'(onehot_mask(6'(bus.din))) ^ INV_MASK;
            end
            dout_valid_d = 1'b1;
        end else if (scan_start) begin
            dout_d       = W'(onehot_mask(6'd0)) ^ INV_MASK;
            dout_valid_d = 1'b1;
        end else if (scan_step) begin
            dout_d       = W'(onehot_mask(6'(idx_next))) ^ INV_MASK;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mode_q  <= MODE_ONEHOT;
            dout_q       <= INV_MASK;
            dout_valid_q <= 1'b0;
        end else begin
            prev_mode_q  <= prev_mode_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.scan_idx   = scan_idx;

endmodule
